change_payout: RTL
==================

CHANGE_PAYOUT -- requirements
Module: change_payout

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have port Clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1 bit: one-cycle change-payout request from the vending controller.
REQ-005 SHALL have port amt, input, 4 bits: change owed in pesos (0-15), sampled with req.
REQ-006 SHALL have ports refill1 and refill5, input, 1 bit each: one-cycle pulse adding one 1-peso or 5-peso coin to inventory.
REQ-007 SHALL have port hop_ack, input, 1 bit: the coin hopper's level acknowledgement of an eject.
REQ-008 SHALL have ports eject1 and eject5, output, 1 bit each: registered eject command, held until acknowledged.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have ports done and err, output, 1 bit each: one-cycle completion and failure pulses.
REQ-011 SHALL have port remaining, output, 4 bits: change not yet paid.
REQ-012 SHALL have ports cnt1 and cnt5, output, 6 bits each: coin inventory.

Function
REQ-013 SHALL implement FSM states IDLE, SEL, EJECT, GAP, DONE and ERR; all outputs SHALL be registered.
REQ-014 IDLE: req=1 SHALL latch remaining=amt and move to SEL; req SHALL be ignored while busy=1.
REQ-015 SEL: remaining=0 SHALL go to DONE; remaining>=5 with cnt5>0 SHALL select the 5-peso coin; otherwise cnt1>0 SHALL select the 1-peso coin; otherwise SHALL go to ERR.
REQ-016 The selected eject line SHALL rise on the clock edge that enters EJECT, two cycles after req is sampled; at most one eject line SHALL be high at any time.
REQ-017 EJECT: hop_ack=1 SHALL drop the eject line, subtract the coin value from remaining, decrement the matching count, and move to GAP.
REQ-018 EJECT SHALL use a 4-bit timeout counter; 16 cycles without hop_ack SHALL go to ERR with remaining and counts unchanged.
REQ-019 GAP SHALL wait for hop_ack=0, then return to SEL.
REQ-020 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-021 ERR SHALL pulse err for one cycle, hold the unpaid amount in remaining, then return to IDLE.
REQ-022 req with amt=0 SHALL produce done two cycles later with no eject.
REQ-023 Refill counters SHALL saturate at 63.
REQ-024 A refill and a decrement on the same count in the same cycle SHALL leave that count unchanged.
REQ-025 Refills SHALL be accepted in every state.

Reset
REQ-026 nrst=0 SHALL immediately force state IDLE and clear eject1, eject5, busy, done, err, remaining, cnt1, cnt5 and the timeout counter, including during EJECT.
REQ-027 The first req accepted after reset deassertion SHALL be the one sampled at the first rising edge with nrst=1.

Structure
REQ-028 SHALL put the coin values (1, 5), the state encoding, TIMEOUT=15 and CNT_W=6 in a shared package vm_pkg.
REQ-029 SHALL implement each inventory as a coin_counter sub-module (saturating 6-bit counter with inc and dec inputs), instantiated twice.

Verification
REQ-030 Refill 5-peso x2 and 1-peso x3, then req amt=7 with ack -> one eject5 and two eject1; done; remaining=0; cnt5=1; cnt1=1.
REQ-031 cnt5=0, cnt1=2, req amt=4 -> two eject1; err pulse; remaining=2; cnt1=0.
REQ-032 cnt1=1, req amt=3, hop_ack held low -> eject1 high for 16 cycles; err; remaining=3; cnt1=1.
REQ-033 req amt=0 -> done two cycles after req; eject1 and eject5 never high.
REQ-034 nrst pulled low during EJECT -> eject deasserted without a clock; busy=0; counts=0.
REQ-035 refill1 in the same cycle as a 1-peso ack -> cnt1 unchanged; refill5 at cnt5=63 -> cnt5 stays 63.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the change payout block.
//   COIN1 / COIN5 : coin values in pesos
//   TIMEOUT       : last EJECT timer value before the eject is abandoned
//   CNT_W         : width of each coin inventory counter
//   state_t       : payout FSM state encoding
package vm_pkg;

    localparam logic [3:0]  COIN1   = 4'd1;
    localparam logic [3:0]  COIN5   = 4'd5;
    localparam logic [3:0]  TIMEOUT = 4'd15;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        EJECT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/coin_counter.sv
// coin_counter: saturating up/down inventory counter for one coin type.
//   Clk   : rising-edge clock
//   nrst  : asynchronous active-low reset, clears count
//   inc   : add one coin (saturates at all-ones)
//   dec   : remove one coin (holds at zero)
//   count : current inventory
// inc and dec together leave the count unchanged.
module coin_counter
    import vm_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         Clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != '1)
                count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/change_payout.sv
// change_payout: pays out change with 5- and 1-peso coins through a hopper.
//   Clk        : rising-edge clock
//   nrst       : asynchronous active-low reset
//   req, amt   : payout request pulse and amount owed (sampled together in IDLE)
//   refill1/5  : one-cycle pulses adding a coin to inventory (any state)
//   hop_ack    : hopper level acknowledge of the current eject
//   eject1/5   : eject command, held until acknowledged or timed out
//   busy       : high whenever not IDLE
//   done, err  : one-cycle completion / failure pulses
//   remaining  : change not yet paid
//   cnt1, cnt5 : coin inventories
// Largest coin first; every output is a flop loaded from next-state logic.
module change_payout
    import vm_pkg::*;
(
    input  logic             Clk,
    input  logic             nrst,
    input  logic             req,
    input  logic [3:0]       amt,
    input  logic             refill1,
    input  logic             refill5,
    input  logic             hop_ack,
    output logic             eject1,
    output logic             eject5,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       remaining,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt5
);

    state_t     state, state_nx;
    logic [3:0] tmr, tmr_nx;
    logic [3:0] rem_nx;
    logic       ej1_nx, ej5_nx;
    logic       dec1, dec5;

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        rem_nx   = remaining;
        ej1_nx   = eject1;
        ej5_nx   = eject5;
        dec1     = 1'b0;
        dec5     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    rem_nx   = amt;
                    state_nx = SEL;
                end
            end
            SEL: begin
                tmr_nx = '0;
                if (remaining == '0) begin
                    state_nx = DONE;
                end else if (remaining >= COIN5 && cnt5 != '0) begin
                    ej5_nx   = 1'b1;
                    state_nx = EJECT;
                end else if (cnt1 != '0) begin
                    ej1_nx   = 1'b1;
                    state_nx = EJECT;
                end else begin
                    state_nx = ERR;
                end
            end
            EJECT: begin
                if (hop_ack) begin
                    ej1_nx   = 1'b0;
                    ej5_nx   = 1'b0;
                    rem_nx   = remaining - (eject5 ? COIN5 : COIN1);
                    dec1     = eject1;
                    dec5     = eject5;
                    state_nx = GAP;
                end else if (tmr == TIMEOUT) begin
                    ej1_nx   = 1'b0;
                    ej5_nx   = 1'b0;
                    state_nx = ERR;
                end else begin
                    tmr_nx = tmr + 4'd1;
                end
            end
            GAP: begin
                if (!hop_ack)
                    state_nx = SEL;
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            tmr       <= '0;
            remaining <= '0;
            eject1    <= 1'b0;
            eject5    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            remaining <= rem_nx;
            eject1    <= ej1_nx;
            eject5    <= ej5_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            err       <= (state_nx == ERR);
        end
    end

    coin_counter #(.W(CNT_W)) u_cnt1 (
        .Clk   (Clk),
        .nrst  (nrst),
        .inc   (refill1),
        .dec   (dec1),
        .count (cnt1)
    );

    coin_counter #(.W(CNT_W)) u_cnt5 (
        .Clk   (Clk),
        .nrst  (nrst),
        .inc   (refill5),
        .dec   (dec5),
        .count (cnt5)
    );

endmodule
